// File: rtl/median_pkg.sv
// Shared types and helpers for the streaming median filter.
// MAX_W bounds the sample width that cswap can handle.
package median_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 6;
    localparam int DEFAULT_N      = 5;
    localparam int MAX_W          = 32;

    // Returns {min, max}; equal operands keep their original order.
    function automatic logic [2*MAX_W-1:0] cswap(input logic [MAX_W-1:0] lo_in,
                                                 input logic [MAX_W-1:0] hi_in);
        if (lo_in > hi_in) begin
            return {hi_in, lo_in};
        end else begin
            return {lo_in, hi_in};
        end
    endfunction

endpackage

// File: rtl/oet_pass.sv
// One combinational odd-even transposition pass over N packed entries.
// parity=0 pairs (0,1),(2,3)...; parity=1 pairs (1,2),(3,4)...
module oet_pass import median_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N      = DEFAULT_N
) (
    input  logic                parity,
    input  logic [N*DATA_W-1:0] din,
    output logic [N*DATA_W-1:0] dout
);

    logic [2*MAX_W-1:0] pair;

    // N is odd, so N/2 pairs always fit for either parity.
    always_comb begin
        dout = din;
        pair = '0;
        for (int p = 0; p < N / 2; p++) begin
            pair = cswap(MAX_W'(din[(2*p + int'(parity))*DATA_W +: DATA_W]),
                         MAX_W'(din[(2*p + int'(parity) + 1)*DATA_W +: DATA_W]));
            dout[(2*p + int'(parity))*DATA_W +: DATA_W]     = DATA_W'(pair[2*MAX_W-1:MAX_W]);
            dout[(2*p + int'(parity) + 1)*DATA_W +: DATA_W] = DATA_W'(pair[MAX_W-1:0]);
        end
    end

endmodule

// File: rtl/median_stream.sv
// Streaming N-tap median filter: sliding window, multi-cycle odd-even
// transposition sort (one pass per clock), registered median output.
module median_stream import median_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N      = DEFAULT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_num
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int PASS_W = $clog2(N);
    localparam int WIN_W  = N * DATA_W;
    localparam int MID    = N / 2;

    if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
        $error("median_stream: N must be odd and >= 3");
    end

    state_t             state;
    state_t             state_next;
    logic [WIN_W-1:0]   window;
    logic [WIN_W-1:0]   window_shifted;
    logic [WIN_W-1:0]   work;
    logic [WIN_W-1:0]   work_next;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_sat;
    logic [PASS_W-1:0]  pass_cnt;
    logic               accept;
    logic               window_full;
    logic               last_pass;

    assign in_ready       = (state == IDLE) && !clear && !rst;
    assign accept         = in_valid && in_ready;
    assign window_shifted = {window[WIN_W-DATA_W-1:0], in_data};
    assign fill_sat       = (fill == FILL_W'(N)) ? fill : fill + FILL_W'(1);
    assign window_full    = (fill_sat == FILL_W'(N));
    assign last_pass      = (pass_cnt == PASS_W'(N - 1));

    oet_pass #(
        .DATA_W (DATA_W),
        .N      (N)
    ) u_pass (
        .parity (pass_cnt[0]),
        .din    (work),
        .dout   (work_next)
    );

    // Next-state logic; clear overrides both handshakes.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && window_full) state_next = SORT;
                    else                       state_next = IDLE;
                end
                SORT: begin
                    if (last_pass) state_next = OUT;
                    else           state_next = SORT;
                end
                OUT: begin
                    if (out_ready) state_next = IDLE;
                    else           state_next = OUT;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sliding window and saturating fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
            fill   <= '0;
        end else if (clear) begin
            window <= '0;
            fill   <= '0;
        end else if (accept) begin
            window <= window_shifted;
            fill   <= fill_sat;
        end else begin
            window <= window;
            fill   <= fill;
        end
    end

    // Sort working copy, pass counter and registered median.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            pass_cnt  <= '0;
            out_valid <= 1'b0;
            out_num   <= '0;
        end else if (clear) begin
            pass_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && window_full) begin
                        work     <= window_shifted;
                        pass_cnt <= '0;
                    end else begin
                        work     <= work;
                    end
                end
                SORT: begin
                    work <= work_next;
                    if (last_pass) begin
                        pass_cnt  <= '0;
                        out_valid <= 1'b1;
                        out_num   <= work_next[MID*DATA_W +: DATA_W];
                    end else begin
                        pass_cnt  <= pass_cnt + PASS_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                    else           out_valid <= 1'b1;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_stream.sv
// Randomised and directed bench for median_stream against a queue-based
// sliding-window median model.
module tb_median_stream;

    localparam int DW = 6;
    localparam int NN = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_num;

    int checks = 0;
    int errors = 0;
    int win[$];

    always #5 clk = ~clk;

    median_stream #(.DATA_W(DW), .N(NN)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int model_median();
        int s[$];
        s = win;
        s.sort();
        return s[NN/2];
    endfunction

    task automatic model_push(input int v);
        win.push_front(v);
        if (win.size() > NN) void'(win.pop_back());
    endtask

    // Offer v from a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int v, output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = DW'(v);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        if (ok) model_push(v);
    endtask

    // cyc counts cycles from the handshake cycle to the first out_valid sample.
    task automatic wait_out(output bit got, output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        got = out_valid;
    endtask

    task automatic feed(input int v, output bit ok, output bit got, output int cyc, output int val);
        push(v, ok);
        got = 1'b0;
        cyc = 0;
        val = -1;
        if (ok && win.size() == NN) begin
            wait_out(got, cyc);
            val = int'(out_num);
            if (out_ready) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_num !== 6'd0)    begin errors++; $display("FAIL reset_out_num: got %0d expected 0", out_num); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_fill_first();
        int vals[5] = '{12, 3, 45, 7, 20};
        bit ok, got;
        int cyc, val;
        for (int i = 0; i < 4; i++) begin
            feed(vals[i], ok, got, cyc, val);
            checks++; if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_no_output[%0d]: ok=%b out_valid=%b in_ready=%b expected ok=1 out_valid=0 in_ready=1", i, ok, out_valid, in_ready); end
        end
        feed(vals[4], ok, got, cyc, val);
        checks++; if (!got || cyc != NN + 1) begin errors++; $display("FAIL first_latency: got valid=%b after %0d cycles expected 1 after %0d", got, cyc, NN + 1); end
        checks++; if (val != 12 || val != model_median()) begin errors++; $display("FAIL first_median: got %0d expected 12", val); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL first_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_slide();
        int vals[2] = '{1, 63};
        int exp_m[2] = '{7, 20};
        bit ok, got;
        int cyc, val;
        for (int i = 0; i < 2; i++) begin
            feed(vals[i], ok, got, cyc, val);
            checks++; if (!got || val != exp_m[i] || val != model_median()) begin errors++; $display("FAIL slide[%0d]: got valid=%b median %0d expected %0d", i, got, val, exp_m[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, got;
        int cyc, exp_v;
        bit bad;
        out_ready = 1'b0;
        push(int'($urandom_range(0, 63)), ok);
        wait_out(got, cyc);
        exp_v = model_median();
        checks++; if (!got || int'(out_num) != exp_v) begin errors++; $display("FAIL bp_median: got valid=%b median %0d expected %0d", got, out_num, exp_v); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom_range(0, 63));
            @(negedge clk);
            if (out_valid !== 1'b1 || int'(out_num) != exp_v || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold: out_valid=%b out_num=%0d in_ready=%b expected 1/%0d/0", out_valid, out_num, in_ready, exp_v); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        checks++; if (int'(out_num) != exp_v) begin errors++; $display("FAIL bp_num_kept: got %0d expected %0d", out_num, exp_v); end
    endtask

    task automatic test_ties();
        int pat[15] = '{63, 63, 0, 0, 63, 0, 0, 0, 0, 0, 5, 5, 5, 9, 1};
        int exp_m[3] = '{63, 0, 5};
        bit ok, got;
        int cyc, val;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 5; i++) begin
                feed(pat[g*5 + i], ok, got, cyc, val);
                checks++; if (!got || val != model_median()) begin errors++; $display("FAIL ties_step[%0d]: got valid=%b median %0d expected %0d", g*5 + i, got, val, model_median()); end
            end
            checks++; if (val != exp_m[g]) begin errors++; $display("FAIL ties_group[%0d]: got %0d expected %0d", g, val, exp_m[g]); end
        end
    endtask

    task automatic recover(input string tag);
        int vals[5] = '{10, 20, 30, 40, 50};
        bit ok, got, seen;
        int cyc, val;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen || in_ready !== 1'b1) begin errors++; $display("FAIL %s_discard: out_valid seen=%b in_ready=%b expected 0/1", tag, seen, in_ready); end
        for (int i = 0; i < 4; i++) begin
            feed(vals[i], ok, got, cyc, val);
            checks++; if (!ok || got || out_valid !== 1'b0) begin errors++; $display("FAIL %s_refill[%0d]: ok=%b out_valid=%b expected 1/0", tag, i, ok, out_valid); end
        end
        feed(vals[4], ok, got, cyc, val);
        checks++; if (!got || val != 30 || val != model_median()) begin errors++; $display("FAIL %s_median: got valid=%b median %0d expected 30", tag, got, val); end
    endtask

    task automatic test_clear_sort();
        bit ok;
        push(int'($urandom_range(0, 63)), ok);
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        win.delete();
        recover("clear");
    endtask

    task automatic test_rst_sort();
        bit ok;
        push(int'($urandom_range(0, 63)), ok);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_num !== 6'd0) begin errors++; $display("FAIL rst_async: out_valid=%b in_ready=%b out_num=%0d expected 0/0/0", out_valid, in_ready, out_num); end
        @(negedge clk);
        rst = 1'b0;
        win.delete();
        recover("rst");
    endtask

    task automatic test_random();
        bit ok, got;
        int cyc, exp_v, d;
        for (int it = 0; it < 30; it++) begin
            out_ready = 1'b0;
            push(int'($urandom_range(0, 63)), ok);
            wait_out(got, cyc);
            exp_v = model_median();
            checks++; if (!got || cyc != NN + 1 || int'(out_num) != exp_v) begin errors++; $display("FAIL rand[%0d]: valid=%b cycles=%0d median %0d expected 1/%0d/%0d", it, got, cyc, out_num, NN + 1, exp_v); end
            d = int'($urandom_range(0, 3));
            repeat (d) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || int'(out_num) != exp_v) begin errors++; $display("FAIL rand_release[%0d]: out_valid=%b out_num=%0d expected 0/%0d", it, out_valid, out_num, exp_v); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_fill_first();
        test_slide();
        test_backpressure();
        test_ties();
        test_clear_sort();
        test_rst_sort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
